// File: rtl/fp32_pkg.sv
// ============================================================================
// Module      : fp32_pkg
// Description : Shared FP32 field widths, constants and accumulator states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fp32_add_comb.sv
// ============================================================================
// Module      : fp32_add_comb
// Description : Combinational binary32 adder, truncating, no subnormals/NaN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp32_add_comb
  import fp32_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);

  logic             a_big;
  logic             s_big;
  logic             same_sign;
  logic [EXP_W-1:0] e_big;
  logic [EXP_W-1:0] e_sml;
  logic [EXP_W-1:0] e_diff;
  logic [EXP_W:0]   e_inc;
  logic [MAN_W:0]   m_big;
  logic [MAN_W:0]   m_sml;
  logic [MAN_W:0]   m_al;
  logic [MAN_W+1:0] m_sum;
  logic [MAN_W:0]   m_diff;
  logic [4:0]       lz;

  always_comb begin
    // Order by magnitude so the subtract path never goes negative.
    a_big     = (a_i[30:0] >= b_i[30:0]);
    s_big     = a_big ? a_i[31] : b_i[31];
    same_sign = (a_i[31] == b_i[31]);
    e_big     = a_big ? a_i[30:23] : b_i[30:23];
    e_sml     = a_big ? b_i[30:23] : a_i[30:23];
    m_big     = {1'b1, (a_big ? a_i[22:0] : b_i[22:0])};
    m_sml     = {1'b1, (a_big ? b_i[22:0] : a_i[22:0])};
    e_diff    = e_big - e_sml;
    m_al      = (e_diff >= 8'd24) ? '0 : (m_sml >> e_diff);
    m_sum     = {1'b0, m_big} + {1'b0, m_al};
    m_diff    = m_big - m_al;
    e_inc     = {1'b0, e_big} + 9'd1;

    lz = '0;
    for (int i = 0; i <= MAN_W; i++) begin
      if (m_diff[i]) lz = 5'(MAN_W - i);
    end

    sum_o = FP_ZERO;
    if (a_i[30:23] == '0) begin
      sum_o = b_i;
    end else if (b_i[30:23] == '0) begin
      sum_o = a_i;
    end else if (same_sign) begin
      if (m_sum[MAN_W+1]) begin
        if (e_inc == 9'd255) sum_o = {s_big, 8'hFF, 23'd0};
        else                 sum_o = {s_big, e_inc[7:0], m_sum[MAN_W:1]};
      end else begin
        sum_o = {s_big, e_big, m_sum[MAN_W-1:0]};
      end
    end else if (m_diff != '0) begin
      // Flush to +0 when normalising would drive the exponent to 0 or below.
      if ({3'd0, lz} < e_big)
        sum_o = {s_big, e_big - {3'd0, lz}, 23'(m_diff << lz)};
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp32_accum.sv
// ============================================================================
// Module      : fp32_accum
// Description : Bias-seeded FP32 stream accumulator with optional ReLU output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp32_accum
  import fp32_pkg::*;
#(
  parameter int LEN_W   = 12,
  parameter bit RELU_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [31:0]      sum;

  function automatic logic [31:0] relu_f(input logic [31:0] v);
    return (RELU_EN && v[31]) ? FP_ZERO : v;
  endfunction

  fp32_add_comb u_add (
    .a_i   (acc_q),
    .b_i   (in_data),
    .sum_o (sum)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = bias;
          cnt_d = len;
          if (len == '0) begin
            state_d    = S_DONE;
            out_data_d = relu_f(bias);
          end else begin
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = sum;
          cnt_d = cnt_q - 1'b1;
          // Result is captured on the last transfer so it is stable in DONE.
          if (cnt_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            state_d    = S_DONE;
            out_data_d = relu_f(sum);
          end
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= FP_ZERO;
      cnt_q      <= '0;
      out_data_q <= FP_ZERO;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_data = out_data_q;
  assign busy     = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fp32_accum.sv
// ============================================================================
// Module      : tb_fp32_accum
// Description : Self-checking bench for fp32_accum (ReLU and pass-through).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp32_accum;

  localparam int LEN_W = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [31:0]      bias;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             out_ready;
  logic             in_ready, out_valid, busy;
  logic [31:0]      out_data;
  logic             in_ready_n, out_valid_n, busy_n;
  logic [31:0]      out_data_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp32_accum #(.LEN_W(LEN_W), .RELU_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  fp32_accum #(.LEN_W(LEN_W), .RELU_EN(1'b0)) u_dut_norelu (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n), .busy(busy_n)
  );

  // Value-level model: integer mantissas scaled by exponent, then renormalised.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    longint ma, mb, mbig, msml, r;
    int     ea, eb, ebig, esml, e;
    logic   sbig, ssml;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0) return b;
    if (eb == 0) return a;
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    if (ea > eb || (ea == eb && ma >= mb)) begin
      mbig = ma; ebig = ea; sbig = a[31]; msml = mb; esml = eb; ssml = b[31];
    end else begin
      mbig = mb; ebig = eb; sbig = b[31]; msml = ma; esml = ea; ssml = a[31];
    end
    if (ebig - esml >= 24) msml = 0;
    else                   msml = msml >> (ebig - esml);
    r = (sbig == ssml) ? mbig + msml : mbig - msml;
    e = ebig;
    if (r == 0) return 32'h0;
    while (r >= (64'd1 << 24)) begin r = r >> 1; e = e + 1; end
    while (r <  (64'd1 << 23)) begin r = r << 1; e = e - 1; end
    if (e >= 255) return {sbig, 8'hFF, 23'd0};
    if (e <= 0)   return 32'h0;
    return {sbig, e[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    e = (($urandom % 8) == 0) ? 8'd0 : 8'(110 + $urandom_range(0, 30));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic kick(input logic [LEN_W-1:0] l, input logic [31:0] b);
    start = 1'b1; len = l; bias = b;
    @(negedge clk);
    start = 1'b0; len = '0; bias = $urandom;
  endtask

  task automatic feed(input logic [31:0] d[$], input bit gaps);
    foreach (d[k]) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = d[k];
      begin
        int guard = 0;
        while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
        if (guard == 20) begin
          n_tests++; n_fail++;
          $display("FAIL feed_timeout: in_ready=%b required=1", in_ready);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid, busy, out_data} !== {3'b000, 32'h0}) begin
      n_fail++;
      $display("FAIL reset: rdy/vld/busy=%b%b%b data=%h required 000/00000000",
               in_ready, out_valid, busy, out_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic(input bit gaps);
    kick(12'd3, 32'h0);
    feed('{32'h3F800000, 32'h40000000, 32'h3F000000}, gaps);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'h40600000) begin
      n_fail++;
      $display("FAIL basic_sum(gaps=%0d): valid=%b data=%h required 1/40600000", gaps, out_valid, out_data);
    end
    release_out();
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_release: valid=%b busy=%b required 0/0", out_valid, busy);
    end
  endtask

  task automatic test_cancel();
    kick(12'd1, 32'h40000000);
    feed('{32'hC0000000}, 1'b0);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL cancel: valid=%b data=%h required 1/00000000", out_valid, out_data);
    end
    release_out();
  endtask

  task automatic test_relu();
    kick(12'd2, 32'h0);
    feed('{32'hBF800000, 32'hC0000000}, 1'b0);
    n_tests++;
    if (out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL relu_on: data=%h required 00000000", out_data);
    end
    n_tests++;
    if (out_data_n !== 32'hC0400000) begin
      n_fail++;
      $display("FAIL relu_off: data=%h required c0400000", out_data_n);
    end
    release_out();
  endtask

  task automatic test_zero_len();
    kick(12'd0, 32'h40400000);
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h40400000) begin
      n_fail++;
      $display("FAIL zero_len: valid=%b ready=%b data=%h required 1/0/40400000",
               out_valid, in_ready, out_data);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    kick(12'd1, 32'h0);
    feed('{32'h3F800000}, 1'b0);
    for (int c = 0; c < 5; c++) begin
      start = 1'b1; len = 12'd2; bias = 32'h41000000;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h3F800000) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: valid=%b ready=%b data=%h required 1/0/3f800000",
                 c, out_valid, in_ready, out_data);
      end
    end
    start = 1'b0;
    release_out();
    n_tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: busy=%b valid=%b required 0/0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    kick(12'd4, 32'h0);
    in_valid = 1'b1; in_data = 32'h3F800000;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({in_ready, out_valid, busy, out_data} !== {3'b000, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_mid: rdy/vld/busy=%b%b%b data=%h required 000/00000000",
               in_ready, out_valid, busy, out_data);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: valid=%b busy=%b required 0/0", out_valid, busy);
    end
    kick(12'd1, 32'h0);
    feed('{32'h3F800000}, 1'b0);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'h3F800000) begin
      n_fail++;
      $display("FAIL after_reset_job: valid=%b data=%h required 1/3f800000", out_valid, out_data);
    end
    release_out();
  endtask

  task automatic test_random();
    for (int j = 0; j < 25; j++) begin
      logic [31:0] q[$];
      logic [31:0] b, acc, exp_relu;
      int n;
      n   = $urandom_range(1, 6);
      b   = rand_fp();
      acc = b;
      q   = {};
      for (int k = 0; k < n; k++) begin
        q.push_back(rand_fp());
        acc = ref_add(acc, q[k]);
      end
      exp_relu = acc[31] ? 32'h0 : acc;
      kick(12'(n), b);
      feed(q, j[0]);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp_relu || out_data_n !== acc) begin
        n_fail++;
        $display("FAIL random_job%0d: valid=%b relu=%h norelu=%h required 1/%h/%h",
                 j, out_valid, out_data, out_data_n, exp_relu, acc);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      release_out();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; bias = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_cancel();
    test_relu();
    test_zero_len();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
